// File: rtl/decode_stage.sv
// Buffered RV32I decode stage: a FIFO of fetched instr/pc pairs feeding a handshaked decoded output register.
// Optional macro DECODE_MEXT_EN enables M-extension (MUL..REMU) decode; otherwise those encodings are illegal.
module decode_stage #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_W-1:0]              out_pc,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [31:0]                  out_imm,
    output logic [PC_W-1:0]              out_target,
    output logic [3:0]                   out_unit,
    output logic                         out_alu_src1,
    output logic                         out_alu_src2,
    output logic [5:0]                   out_alu_mode,
    output logic [2:0]                   out_shifter_mode,
    output logic [2:0]                   out_cmp_mode,
    output logic                         out_reg_we,
    output logic                         out_mem_re,
    output logic                         out_mem_we,
    output logic [1:0]                   out_mem_mode,
    output logic                         out_mem_signed,
    output logic                         out_is_branch,
    output logic                         out_is_jal,
    output logic                         out_is_jalr,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] UNIT_ALU = 4'b0001;
    localparam logic [3:0] UNIT_SHF = 4'b0010;
    localparam logic [3:0] UNIT_CMP = 4'b0100;
    localparam logic [3:0] UNIT_MD  = 4'b1000;

    localparam logic [5:0] ALU_ADD  = 6'b100101;
    localparam logic [5:0] ALU_SUB  = 6'b011011;
    localparam logic [5:0] ALU_OR   = 6'b111010;
    localparam logic [5:0] ALU_AND  = 6'b100010;
    localparam logic [5:0] ALU_XOR  = 6'b011010;
    localparam logic [5:0] ALU_PASS = 6'b101010;
    localparam logic [5:0] ALU_ZERO = 6'b000010;

    localparam logic [2:0] SHF_LSR = 3'b001;
    localparam logic [2:0] SHF_LSL = 3'b010;
    localparam logic [2:0] SHF_ASR = 3'b100;

    localparam logic [2:0] CMP_LT  = 3'b000;
    localparam logic [2:0] CMP_LTU = 3'b001;
    localparam logic [2:0] CMP_GE  = 3'b010;
    localparam logic [2:0] CMP_GEU = 3'b011;
    localparam logic [2:0] CMP_EQ  = 3'b100;
    localparam logic [2:0] CMP_NEQ = 3'b101;

    logic [31:0]     fifo_instr [DEPTH];
    logic [PC_W-1:0] fifo_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            empty, full, push, load;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    // Gating with rst_n keeps the stage closed while reset is held.
    assign in_ready   = rst_n && !full && !flush;
    assign push       = in_valid && in_ready;
    assign load       = !empty && (!out_valid || out_ready) && !flush;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= in_instr;
            fifo_pc[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            if (push && !load)      count <= count + CW'(1);
            else if (!push && load) count <= count - CW'(1);
        end
    end

    logic [31:0]     h_instr;
    logic [PC_W-1:0] h_pc;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [31:0]     i_imm, s_imm, b_imm, u_imm, j_imm, t_imm;

    assign h_instr = fifo_instr[rd_ptr];
    assign h_pc    = fifo_pc[rd_ptr];
    assign opcode  = h_instr[6:0];
    assign funct3  = h_instr[14:12];
    assign funct7  = h_instr[31:25];
    assign i_imm   = {{20{h_instr[31]}}, h_instr[31:20]};
    assign s_imm   = {{20{h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
    assign b_imm   = {{19{h_instr[31]}}, h_instr[31], h_instr[7], h_instr[30:25], h_instr[11:8], 1'b0};
    assign u_imm   = {h_instr[31:12], 12'b0};
    assign j_imm   = {{11{h_instr[31]}}, h_instr[31], h_instr[19:12], h_instr[20], h_instr[30:21], 1'b0};

    logic [31:0]     d_imm;
    logic [PC_W-1:0] d_target;
    logic [3:0]      d_unit;
    logic            d_src1, d_src2, d_reg_we, d_mem_re, d_mem_we, d_mem_signed;
    logic [5:0]      d_alu_mode;
    logic [2:0]      d_shf_mode, d_cmp_mode;
    logic [1:0]      d_mem_mode;
    logic            d_is_branch, d_is_jal, d_is_jalr, d_illegal;

    always_comb begin
        d_imm        = '0;
        d_unit       = '0;
        d_src1       = 1'b0;
        d_src2       = 1'b0;
        d_alu_mode   = ALU_ZERO;
        d_shf_mode   = '0;
        d_cmp_mode   = '0;
        d_reg_we     = 1'b0;
        d_mem_re     = 1'b0;
        d_mem_we     = 1'b0;
        d_mem_mode   = '0;
        d_mem_signed = 1'b1;
        d_is_branch  = 1'b0;
        d_is_jal     = 1'b0;
        d_is_jalr    = 1'b0;
        d_illegal    = 1'b0;
        t_imm        = '0;
        case (opcode)
            OP_R: begin
                d_reg_we = 1'b1;
                d_unit   = UNIT_ALU;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000: d_alu_mode = ALU_ADD;
                            3'b001: begin d_unit = UNIT_SHF; d_shf_mode = SHF_LSL; end
                            3'b010: begin d_unit = UNIT_CMP; d_cmp_mode = CMP_LT; end
                            3'b011: begin d_unit = UNIT_CMP; d_cmp_mode = CMP_LTU; end
                            3'b100: d_alu_mode = ALU_XOR;
                            3'b101: begin d_unit = UNIT_SHF; d_shf_mode = SHF_LSR; end
                            3'b110: d_alu_mode = ALU_OR;
                            default: d_alu_mode = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) d_alu_mode = ALU_SUB;
                        else if (funct3 == 3'b101) begin
                            d_unit     = UNIT_SHF;
                            d_shf_mode = SHF_ASR;
                        end else d_illegal = 1'b1;
                    end
                    7'b0000001: begin
`ifdef DECODE_MEXT_EN
                        d_unit     = UNIT_MD;
                        d_alu_mode = {3'b000, funct3};
`else
                        d_illegal  = 1'b1;
`endif
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                d_reg_we = 1'b1;
                d_src2   = 1'b1;
                d_unit   = UNIT_ALU;
                d_imm    = i_imm;
                case (funct3)
                    3'b000: d_alu_mode = ALU_ADD;
                    3'b010: begin d_unit = UNIT_CMP; d_cmp_mode = CMP_LT; end
                    3'b011: begin d_unit = UNIT_CMP; d_cmp_mode = CMP_LTU; end
                    3'b100: d_alu_mode = ALU_XOR;
                    3'b110: d_alu_mode = ALU_OR;
                    3'b111: d_alu_mode = ALU_AND;
                    3'b001: begin
                        d_unit     = UNIT_SHF;
                        d_shf_mode = SHF_LSL;
                        d_imm      = {27'b0, h_instr[24:20]};
                        if (funct7 != 7'b0000000) d_illegal = 1'b1;
                    end
                    default: begin
                        d_unit = UNIT_SHF;
                        d_imm  = {27'b0, h_instr[24:20]};
                        if (funct7 == 7'b0000000)      d_shf_mode = SHF_LSR;
                        else if (funct7 == 7'b0100000) d_shf_mode = SHF_ASR;
                        else                           d_illegal  = 1'b1;
                    end
                endcase
            end
            OP_LOAD: begin
                d_unit       = UNIT_ALU;
                d_alu_mode   = ALU_ADD;
                d_src2       = 1'b1;
                d_imm        = i_imm;
                d_reg_we     = 1'b1;
                d_mem_re     = 1'b1;
                d_mem_mode   = funct3[1:0];
                d_mem_signed = !funct3[2];
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) d_illegal = 1'b1;
            end
            OP_STORE: begin
                d_unit     = UNIT_ALU;
                d_alu_mode = ALU_ADD;
                d_src2     = 1'b1;
                d_imm      = s_imm;
                d_mem_we   = 1'b1;
                d_mem_mode = funct3[1:0];
                if (funct3 > 3'b010) d_illegal = 1'b1;
            end
            OP_BRANCH: begin
                d_unit      = UNIT_CMP;
                d_imm       = b_imm;
                t_imm       = b_imm;
                d_is_branch = 1'b1;
                case (funct3)
                    3'b000:  d_cmp_mode = CMP_EQ;
                    3'b001:  d_cmp_mode = CMP_NEQ;
                    3'b100:  d_cmp_mode = CMP_LT;
                    3'b101:  d_cmp_mode = CMP_GE;
                    3'b110:  d_cmp_mode = CMP_LTU;
                    3'b111:  d_cmp_mode = CMP_GEU;
                    default: d_illegal  = 1'b1;
                endcase
            end
            OP_LUI: begin
                d_unit     = UNIT_ALU;
                d_alu_mode = ALU_PASS;
                d_src2     = 1'b1;
                d_imm      = u_imm;
                d_reg_we   = 1'b1;
            end
            OP_AUIPC: begin
                d_unit     = UNIT_ALU;
                d_alu_mode = ALU_ADD;
                d_src1     = 1'b1;
                d_src2     = 1'b1;
                d_imm      = u_imm;
                d_reg_we   = 1'b1;
            end
            // Jumps compute the link value pc+4 in the ALU; the jump target travels separately.
            OP_JAL, OP_JALR: begin
                d_unit     = UNIT_ALU;
                d_alu_mode = ALU_ADD;
                d_src1     = 1'b1;
                d_src2     = 1'b1;
                d_imm      = 32'd4;
                d_reg_we   = 1'b1;
                if (opcode == OP_JAL) begin
                    d_is_jal = 1'b1;
                    t_imm    = j_imm;
                end else begin
                    d_is_jalr = 1'b1;
                    if (funct3 != 3'b000) d_illegal = 1'b1;
                end
            end
            OP_FENCE, OP_SYSTEM: ;
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_imm        = '0;
            d_unit       = '0;
            d_src1       = 1'b0;
            d_src2       = 1'b0;
            d_alu_mode   = ALU_ZERO;
            d_shf_mode   = '0;
            d_cmp_mode   = '0;
            d_reg_we     = 1'b0;
            d_mem_re     = 1'b0;
            d_mem_we     = 1'b0;
            d_mem_mode   = '0;
            d_mem_signed = 1'b1;
            d_is_branch  = 1'b0;
            d_is_jal     = 1'b0;
            d_is_jalr    = 1'b0;
        end
        if (h_instr[11:7] == 5'd0) d_reg_we = 1'b0;
        d_target = (d_is_branch || d_is_jal) ? h_pc + PC_W'($signed(t_imm)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_pc           <= '0;
            out_rd           <= '0;
            out_rs1          <= '0;
            out_rs2          <= '0;
            out_imm          <= '0;
            out_target       <= '0;
            out_unit         <= '0;
            out_alu_src1     <= 1'b0;
            out_alu_src2     <= 1'b0;
            out_alu_mode     <= ALU_ZERO;
            out_shifter_mode <= '0;
            out_cmp_mode     <= '0;
            out_reg_we       <= 1'b0;
            out_mem_re       <= 1'b0;
            out_mem_we       <= 1'b0;
            out_mem_mode     <= '0;
            out_mem_signed   <= 1'b1;
            out_is_branch    <= 1'b0;
            out_is_jal       <= 1'b0;
            out_is_jalr      <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid        <= 1'b1;
            out_pc           <= h_pc;
            out_rd           <= h_instr[11:7];
            out_rs1          <= h_instr[19:15];
            out_rs2          <= h_instr[24:20];
            out_imm          <= d_imm;
            out_target       <= d_target;
            out_unit         <= d_unit;
            out_alu_src1     <= d_src1;
            out_alu_src2     <= d_src2;
            out_alu_mode     <= d_alu_mode;
            out_shifter_mode <= d_shf_mode;
            out_cmp_mode     <= d_cmp_mode;
            out_reg_we       <= d_reg_we;
            out_mem_re       <= d_mem_re;
            out_mem_we       <= d_mem_we;
            out_mem_mode     <= d_mem_mode;
            out_mem_signed   <= d_mem_signed;
            out_is_branch    <= d_is_branch;
            out_is_jal       <= d_is_jal;
            out_is_jalr      <= d_is_jalr;
            out_illegal      <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; M-extension expectations follow DECODE_MEXT_EN.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm, out_target;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [3:0]  out_unit;
    logic        out_alu_src1, out_alu_src2;
    logic [5:0]  out_alu_mode;
    logic [2:0]  out_shifter_mode, out_cmp_mode;
    logic        out_reg_we, out_mem_re, out_mem_we, out_mem_signed;
    logic [1:0]  out_mem_mode;
    logic        out_is_branch, out_is_jal, out_is_jalr, out_illegal;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    decode_stage #(.DEPTH(4), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_target(out_target), .out_unit(out_unit),
        .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
        .out_alu_mode(out_alu_mode), .out_shifter_mode(out_shifter_mode),
        .out_cmp_mode(out_cmp_mode), .out_reg_we(out_reg_we),
        .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_mem_mode(out_mem_mode), .out_mem_signed(out_mem_signed),
        .out_is_branch(out_is_branch), .out_is_jal(out_is_jal),
        .out_is_jalr(out_is_jalr), .out_illegal(out_illegal),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push one entry, then one more edge so it sits in the output register.
    task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_alu_mode", out_alu_mode, 6'b000010);
        check("rst_mem_signed", out_mem_signed, 1);
        check("rst_unit", out_unit, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // addi x1,x0,5
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
        tick();
        in_valid = 1'b0;
        check("addi_not_yet", out_valid, 0);
        check("addi_count", fifo_count, 1);
        tick();
        check("addi_valid", out_valid, 1);
        check("addi_imm", out_imm, 5);
        check("addi_unit", out_unit, 4'b0001);
        check("addi_alu", out_alu_mode, 6'b100101);
        check("addi_src2", out_alu_src2, 1);
        check("addi_we", out_reg_we, 1);
        check("addi_rd", out_rd, 1);
        check("addi_pc", out_pc, 32'h100);

        // sub then srai back to back
        in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h104;
        tick();
        check("drain_after_addi", out_valid, 0);
        in_instr = 32'h40335293; in_pc = 32'h108;
        tick();
        in_valid = 1'b0;
        check("sub_valid", out_valid, 1);
        check("sub_alu", out_alu_mode, 6'b011011);
        check("sub_rd", out_rd, 3);
        check("sub_src2", out_alu_src2, 0);
        tick();
        check("srai_valid", out_valid, 1);
        check("srai_unit", out_unit, 4'b0010);
        check("srai_shf", out_shifter_mode, 3'b100);
        check("srai_imm", out_imm, 3);
        check("srai_src2", out_alu_src2, 1);
        check("srai_illegal", out_illegal, 0);
        tick();
        check("srai_drained", out_valid, 0);

        // beq +8 at 0x200, jal x1,+16 at 0x300
        in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 32'h200;
        tick();
        in_instr = 32'h010000EF; in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        check("beq_target", out_target, 32'h208);
        check("beq_cmp", out_cmp_mode, 3'b100);
        check("beq_branch", out_is_branch, 1);
        check("beq_unit", out_unit, 4'b0100);
        check("beq_we", out_reg_we, 0);
        tick();
        check("jal_target", out_target, 32'h310);
        check("jal_imm", out_imm, 4);
        check("jal_flag", out_is_jal, 1);
        check("jal_src1", out_alu_src1, 1);
        check("jal_we", out_reg_we, 1);
        check("jal_branch", out_is_branch, 0);
        tick();

        // Stall: fill FIFO plus output register
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000093 | (32'(10 + k) << 20);
            in_pc    = 32'h400 + 32'(4 * k);
            tick();
        end
        check("full_count", fifo_count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_out_pc", out_pc, 32'h400);
        in_instr = 32'h00000093 | (32'd99 << 20); in_pc = 32'h500;
        tick();
        tick();
        check("stall_pc", out_pc, 32'h400);
        check("stall_imm", out_imm, 10);
        check("stall_count", fifo_count, 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_pc", out_pc, 32'h400 + 32'(4 * k));
            check("drain_imm", out_imm, 32'(10 + k));
            tick();
        end
        check("drain_done_valid", out_valid, 0);
        check("drain_done_count", fifo_count, 0);

        // Flush with 3 queued and one held
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h00000093 | (32'(20 + k) << 20);
            in_pc    = 32'h600 + 32'(4 * k);
            tick();
        end
        check("preflush_count", fifo_count, 3);
        check("preflush_valid", out_valid, 1);
        flush = 1'b1;
        in_instr = 32'h00000093 | (32'd77 << 20); in_pc = 32'h700;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("flush_count", fifo_count, 0);
        check("flush_valid", out_valid, 0);
        tick();
        check("flush_dropped_valid", out_valid, 0);
        check("flush_dropped_count", fifo_count, 0);

        // mul x3,x1,x2
        send_one(32'h022081B3, 32'h800);
        check("mul_valid", out_valid, 1);
`ifdef DECODE_MEXT_EN
        check("mul_unit", out_unit, 4'b1000);
        check("mul_illegal", out_illegal, 0);
        check("mul_we", out_reg_we, 1);
        check("mul_alu", out_alu_mode, 6'b000000);
`else
        check("mul_illegal", out_illegal, 1);
        check("mul_we", out_reg_we, 0);
        check("mul_unit", out_unit, 4'b0000);
`endif

        // addi x0,x0,0
        send_one(32'h00000013, 32'h804);
        check("x0_we", out_reg_we, 0);
        check("x0_unit", out_unit, 4'b0001);
        check("x0_illegal", out_illegal, 0);

        // lbu x1,0(x0)
        send_one(32'h0000C083, 32'h808);
        check("lbu_re", out_mem_re, 1);
        check("lbu_signed", out_mem_signed, 0);
        check("lbu_mode", out_mem_mode, 2'b00);
        check("lbu_illegal", out_illegal, 0);

        // LOAD funct3=011 is illegal
        send_one(32'h00003083, 32'h80C);
        check("ld_illegal", out_illegal, 1);
        check("ld_re", out_mem_re, 0);
        check("ld_unit", out_unit, 0);

        // slli x1,x1,2 with bad funct7 0100000 is illegal
        send_one(32'h40209093, 32'h810);
        check("slli_bad_illegal", out_illegal, 1);

        // bge funct3=101 and fence as NOP
        send_one(32'h0020D463, 32'h900);
        check("bge_cmp", out_cmp_mode, 3'b010);
        check("bge_target", out_target, 32'h908);
        send_one(32'h0000000F, 32'h904);
        check("fence_illegal", out_illegal, 0);
        check("fence_unit", out_unit, 0);
        check("fence_target", out_target, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
